// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam int unsigned pc_size     = 32;
  localparam int unsigned instr_size  = 32;
  localparam int unsigned opcode_size = 7;

  localparam logic [opcode_size-1:0] btype_op = 7'b1100011;
  localparam logic [opcode_size-1:0] jal_op   = 7'b1101111;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [instr_size-1:0] instr;
    logic [pc_size-1:0]    pc;
    logic [pc_size-1:0]    pcplf;
  } fetch_entry_t;

  // PC+4 wraps modulo 2^pc_size.
  function automatic logic [pc_size-1:0] pc_plus4(input logic [pc_size-1:0] pc);
    return pc + pc_size'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory, BPU and decode-side signals of the fetch stage.
interface fetch_stage_if import fetch_stage_pkg::*; ();

  logic                   imem_req;
  logic [pc_size-1:0]     imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [instr_size-1:0]  imem_rdata;

  logic [pc_size-1:0]     bpu_pc;
  logic [pc_size-1:0]     bpu_pcplf;
  logic [opcode_size-1:0] bpu_op;
  logic                   bpu_pc_en;
  logic [pc_size-1:0]     bpu_npc;
  logic                   bpu_mux_sel;
  logic                   bpu_chng2nop;

  logic                   id_valid;
  logic                   id_ready;
  logic [instr_size-1:0]  id_instr;
  logic [pc_size-1:0]     id_pc;
  logic [pc_size-1:0]     id_pcplf;
  logic                   id_flush;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output bpu_pc, bpu_pcplf, bpu_op, bpu_pc_en,
    input  bpu_npc, bpu_mux_sel, bpu_chng2nop,
    output id_valid, id_instr, id_pc, id_pcplf, id_flush,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  bpu_pc, bpu_pcplf, bpu_op, bpu_pc_en,
    output bpu_npc, bpu_mux_sel, bpu_chng2nop,
    input  id_valid, id_instr, id_pc, id_pcplf, id_flush,
    output id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions with 1-bit wrapping pointers and a flush.
module fetch_queue import fetch_stage_pkg::*; #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'(QDEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the fetch PC, talks req/gnt/rvalid to imem, feeds the BPU and decode.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [pc_size-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned        QDEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  fetch_state_t       r_state;
  logic [pc_size-1:0] r_fetch_pc;
  logic               r_kill;
  logic               r_id_flush;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_count;
  logic [1:0]         w_count_next;
  logic               w_room;
  logic [pc_size-1:0] w_pc_plf;
  fetch_entry_t       w_entry;
  fetch_entry_t       w_head;

  assign w_pc_plf = pc_plus4(r_fetch_pc);
  assign w_accept = (r_state == WAIT) && bus.imem_rvalid && !r_kill;
  assign w_push   = w_accept && !bus.bpu_chng2nop;
  assign w_pop    = bus.id_ready && !w_empty;
  assign w_entry  = '{instr: bus.imem_rdata, pc: r_fetch_pc, pcplf: w_pc_plf};

  assign w_count_next = bus.bpu_chng2nop ? 2'd0 : (w_count + 2'(w_push) - 2'(w_pop));
  assign w_room       = (w_count_next < 2'(QDEPTH));

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.bpu_chng2nop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REQ;
      r_fetch_pc <= BOOT_ADDR;
      r_kill     <= 1'b0;
      r_id_flush <= 1'b0;
    end else begin
      r_id_flush <= bus.bpu_chng2nop;
      case (r_state)
        REQ: begin
          if (bus.bpu_mux_sel) r_fetch_pc <= bus.bpu_npc;
          if (bus.imem_gnt) begin
            // A redirect in the grant cycle makes the just-issued request wrong-path.
            r_kill  <= bus.bpu_mux_sel;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill) begin
              if (bus.bpu_mux_sel) r_fetch_pc <= bus.bpu_npc;
              r_state <= REQ;
            end else begin
              r_fetch_pc <= bus.bpu_mux_sel ? bus.bpu_npc : w_pc_plf;
              r_state    <= w_room ? REQ : HOLD;
            end
          end else if (bus.bpu_mux_sel) begin
            r_fetch_pc <= bus.bpu_npc;
            r_kill     <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.bpu_mux_sel) r_fetch_pc <= bus.bpu_npc;
          if (!w_full || w_pop || bus.bpu_chng2nop) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign bus.imem_req  = (r_state == REQ);
  assign bus.imem_addr = r_fetch_pc;

  assign bus.bpu_pc    = r_fetch_pc;
  assign bus.bpu_pcplf = w_pc_plf;
  assign bus.bpu_pc_en = w_accept;
  assign bus.bpu_op    = w_accept ? bus.imem_rdata[opcode_size-1:0] : '0;

  assign bus.id_valid  = !w_empty;
  assign bus.id_instr  = w_head.instr;
  assign bus.id_pc     = w_head.pc;
  assign bus.id_pcplf  = w_head.pcplf;
  assign bus.id_flush  = r_id_flush;

endmodule
